// File: rtl/receptor_movimentos.sv
// Serial move-list receiver: UART (8N1, or 8E1 with RECEPTOR_PARIDADE_EN) feeding a
// decoder that writes 3-bit move codes sequentially into the movement RAM.
module receptor_movimentos #(
    parameter int CLKS_POR_BIT   = 434,
    parameter int MAX_MOVIMENTOS = 480
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       rx_serial,
    output logic [8:0] w_addr_movimento,
    output logic       we_movimento,
    output logic [2:0] w_data_movimento,
    output logic [8:0] num_movimentos,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);
    localparam int CW = $clog2(CLKS_POR_BIT);
    localparam logic [CW-1:0] C_MEIO = CW'(CLKS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] C_BIT  = CW'(CLKS_POR_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO, START, DADOS, PARIDADE, STOP
    } uart_t;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ESPERA     = 4'd1,
        DECODIFICA = 4'd2,
        ESCREVE    = 4'd3,
        INCREMENTA = 4'd4,
        FINAL      = 4'd5,
        ERRO       = 4'd6
    } estado_t;

    logic          r_rx_s1, r_rx_sinc, r_rx_ant;
    uart_t         r_uart, w_uart_prox;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_dado;
    logic          r_byte_valido, r_erro_quadro;
    logic          w_tc, w_carrega_meio, w_carrega_bit, w_erro_stop;

    estado_t       r_estado, w_estado_prox;
    logic [8:0]    r_count;
    logic [2:0]    r_codigo;
    logic          w_we, w_limpa, w_inc, w_grava;
    logic          w_eh_digito;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_s1   <= 1'b0;
            r_rx_sinc <= 1'b0;
            r_rx_ant  <= 1'b0;
        end else begin
            r_rx_s1   <= rx_serial;
            r_rx_sinc <= r_rx_s1;
            r_rx_ant  <= r_rx_sinc;
        end
    end

    assign w_tc = (r_cnt == '0);

    always_comb begin
        w_uart_prox    = r_uart;
        w_carrega_meio = 1'b0;
        w_carrega_bit  = 1'b0;
        case (r_uart)
            OCIOSO: if (r_rx_ant && !r_rx_sinc) begin
                w_uart_prox    = START;
                w_carrega_meio = 1'b1;
            end
            START: if (w_tc) begin
                if (r_rx_sinc) begin
                    w_uart_prox = OCIOSO;
                end else begin
                    w_uart_prox   = DADOS;
                    w_carrega_bit = 1'b1;
                end
            end
            DADOS: if (w_tc) begin
                w_carrega_bit = 1'b1;
                if (r_bit_idx == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                    w_uart_prox = PARIDADE;
`else
                    w_uart_prox = STOP;
`endif
                end
            end
            PARIDADE: if (w_tc) begin
                w_uart_prox   = STOP;
                w_carrega_bit = 1'b1;
            end
            STOP: if (w_tc) w_uart_prox = OCIOSO;
            default: w_uart_prox = OCIOSO;
        endcase
    end

`ifdef RECEPTOR_PARIDADE_EN
    logic r_par_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_par_err <= 1'b0;
        else if (r_uart == PARIDADE && w_tc)
            r_par_err <= ^{r_dado, r_rx_sinc};
    end

    assign w_erro_stop = !r_rx_sinc || r_par_err;
`else
    assign w_erro_stop = !r_rx_sinc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_uart        <= OCIOSO;
            r_cnt         <= '0;
            r_bit_idx     <= 3'd0;
            r_dado        <= 8'd0;
            r_byte_valido <= 1'b0;
            r_erro_quadro <= 1'b0;
        end else begin
            r_uart <= w_uart_prox;
            if (w_carrega_meio)
                r_cnt <= C_MEIO;
            else if (w_carrega_bit)
                r_cnt <= C_BIT;
            else if (!w_tc)
                r_cnt <= r_cnt - CW'(1);
            if (w_carrega_meio)
                r_bit_idx <= 3'd0;
            else if (r_uart == DADOS && w_tc)
                r_bit_idx <= r_bit_idx + 3'd1;
            // LSB arrives first, so shift in from the top
            if (r_uart == DADOS && w_tc)
                r_dado <= {r_rx_sinc, r_dado[7:1]};
            r_byte_valido <= (r_uart == STOP) && w_tc;
            if (r_uart == STOP && w_tc)
                r_erro_quadro <= w_erro_stop;
        end
    end

    assign w_eh_digito = (r_dado >= 8'h30) && (r_dado <= 8'h35);

    always_comb begin
        w_estado_prox = r_estado;
        w_we          = 1'b0;
        w_limpa       = 1'b0;
        w_inc         = 1'b0;
        w_grava       = 1'b0;
        case (r_estado)
            INICIAL, FINAL, ERRO: if (iniciar) begin
                w_estado_prox = ESPERA;
                w_limpa       = 1'b1;
            end
            ESPERA: if (r_byte_valido) w_estado_prox = DECODIFICA;
            DECODIFICA: begin
                if (r_erro_quadro) begin
                    w_estado_prox = ERRO;
                end else if (w_eh_digito) begin
                    w_estado_prox = ESCREVE;
                    w_grava       = 1'b1;
                end else if (r_dado == 8'h23) begin
                    w_estado_prox = FINAL;
                end else begin
                    w_estado_prox = ERRO;
                end
            end
            ESCREVE: begin
                w_we          = 1'b1;
                w_estado_prox = INCREMENTA;
            end
            INCREMENTA: begin
                w_inc = 1'b1;
                // the count being incremented reaches the RAM depth: list is full
                if (r_count == 9'(MAX_MOVIMENTOS - 1))
                    w_estado_prox = FINAL;
                else
                    w_estado_prox = ESPERA;
            end
            default: w_estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_count  <= 9'd0;
            r_codigo <= 3'd0;
        end else begin
            r_estado <= w_estado_prox;
            if (w_limpa)
                r_count <= 9'd0;
            else if (w_inc)
                r_count <= r_count + 9'd1;
            if (w_grava)
                r_codigo <= r_dado[2:0];
        end
    end

    assign w_addr_movimento = r_count;
    assign num_movimentos   = r_count;
    assign we_movimento     = w_we;
    assign w_data_movimento = r_codigo;
    assign pronto           = (r_estado == FINAL);
    assign erro             = (r_estado == ERRO);
    assign db_estado        = r_estado;

endmodule

// File: tb/tb_receptor_movimentos.sv
// Directed bench for receptor_movimentos (CLKS_POR_BIT=16, MAX_MOVIMENTOS=4); honours RECEPTOR_PARIDADE_EN.
module tb_receptor_movimentos;
    localparam int CPB = 16;

    logic       clock, reset, iniciar, rx_serial;
    logic [8:0] w_addr_movimento, num_movimentos;
    logic       we_movimento, pronto, erro;
    logic [2:0] w_data_movimento;
    logic [3:0] db_estado;

    receptor_movimentos #(.CLKS_POR_BIT(CPB), .MAX_MOVIMENTOS(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .rx_serial(rx_serial),
        .w_addr_movimento(w_addr_movimento), .we_movimento(we_movimento),
        .w_data_movimento(w_data_movimento), .num_movimentos(num_movimentos),
        .pronto(pronto), .erro(erro), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [8:0] a; logic [2:0] d; } wr_t;
    wr_t wq[$];
    always @(negedge clock) if (we_movimento) wq.push_back('{w_addr_movimento, w_data_movimento});

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         est;
        int         nwr;
        int         dat;
    } vec_t;
    vec_t vt[8];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_wr(input string nm, input int idx, input int a, input int d);
        if (idx >= wq.size()) begin
            n_chk++;
            $display("FAIL %s: only %0d writes seen, expected write #%0d", nm, wq.size(), idx);
        end else begin
            chk({nm, "_addr"}, int'(wq[idx].a), a);
            chk({nm, "_data"}, int'(wq[idx].d), d);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        wq.delete();
    endtask

    task automatic pulse_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_flip);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef RECEPTOR_PARIDADE_EN
        rx_serial = (^b) ^ par_flip;
        repeat (CPB) @(negedge clock);
`endif
        rx_serial = stop_b;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    initial begin
        vt[0] = '{8'h30, 1'b1, 1, 1, 0};
        vt[1] = '{8'h35, 1'b1, 1, 1, 5};
        vt[2] = '{8'h31, 1'b1, 1, 1, 1};
        vt[3] = '{8'h23, 1'b1, 5, 0, 0};
        vt[4] = '{8'h36, 1'b1, 6, 0, 0};
        vt[5] = '{8'h2F, 1'b1, 6, 0, 0};
        vt[6] = '{8'h58, 1'b1, 6, 0, 0};
        vt[7] = '{8'h33, 1'b0, 6, 0, 0};

        reset = 1'b1; iniciar = 1'b0; rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_addr", w_addr_movimento, 0);
        chk("rst_we", we_movimento, 0);
        chk("rst_data", w_data_movimento, 0);
        chk("rst_num", num_movimentos, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_erro", erro, 0);
        chk("rst_estado", db_estado, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("idle_estado", db_estado, 0);

        // full list "305#"
        pulse_iniciar();
        chk("ini_estado", db_estado, 1);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        send_byte(8'h35, 1'b1, 1'b0);
        send_byte(8'h23, 1'b1, 1'b0);
        chk("lista_nwr", wq.size(), 3);
        chk_wr("lista_w0", 0, 0, 3);
        chk_wr("lista_w1", 1, 1, 0);
        chk_wr("lista_w2", 2, 2, 5);
        chk("lista_pronto", pronto, 1);
        chk("lista_num", num_movimentos, 3);
        chk("lista_erro", erro, 0);

        // invalid byte, then ignored byte while in ERRO
        wq.delete();
        pulse_iniciar();
        chk("inv_num_clr", num_movimentos, 0);
        send_byte(8'h32, 1'b1, 1'b0);
        send_byte(8'h58, 1'b1, 1'b0);
        chk("inv_nwr", wq.size(), 1);
        chk_wr("inv_w0", 0, 0, 2);
        chk("inv_erro", erro, 1);
        chk("inv_pronto", pronto, 0);
        chk("inv_num", num_movimentos, 1);
        send_byte(8'h31, 1'b1, 1'b0);
        chk("inv_ignorado_nwr", wq.size(), 1);
        chk("inv_ignorado_estado", db_estado, 6);

        // false start glitch in ESPERA, then a real byte still decodes
        wq.delete();
        pulse_iniciar();
        rx_serial = 1'b0;
        repeat (4) @(negedge clock);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        chk("falso_estado", db_estado, 1);
        chk("falso_nwr", wq.size(), 0);
        send_byte(8'h34, 1'b1, 1'b0);
        chk_wr("falso_depois", 0, 0, 4);

        // full RAM at depth 4
        do_reset();
        pulse_iniciar();
        for (int i = 0; i < 4; i++) send_byte(8'h31, 1'b1, 1'b0);
        chk("cheia_pronto", pronto, 1);
        chk("cheia_num", num_movimentos, 4);
        send_byte(8'h31, 1'b1, 1'b0);
        chk("cheia_nwr", wq.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr($sformatf("cheia_w%0d", i), i, i, 1);
        chk("cheia_pronto5", pronto, 1);

        // reset during bit 4 of the second byte
        do_reset();
        pulse_iniciar();
        send_byte(8'h31, 1'b1, 1'b0);
        chk("meio_num_antes", num_movimentos, 1);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx_serial = 1'(8'h32 >> i);
            repeat (CPB) @(negedge clock);
        end
        rx_serial = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("meio_num", num_movimentos, 0);
        chk("meio_addr", w_addr_movimento, 0);
        chk("meio_estado", db_estado, 0);
        chk("meio_data", w_data_movimento, 0);
        chk("meio_flags", {pronto, erro, we_movimento}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);
        wq.delete();
        pulse_iniciar();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h23, 1'b1, 1'b0);
        chk("meio_nwr", wq.size(), 1);
        chk_wr("meio_w0", 0, 0, 4);
        chk("meio_pronto", pronto, 1);

        // single-byte decode table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pulse_iniciar();
            send_byte(vt[v].b, vt[v].stop, 1'b0);
            chk($sformatf("vet%0d_estado", v), db_estado, vt[v].est);
            chk($sformatf("vet%0d_nwr", v), wq.size(), vt[v].nwr);
            chk($sformatf("vet%0d_num", v), num_movimentos, vt[v].nwr);
            if (vt[v].nwr > 0) chk_wr($sformatf("vet%0d_w", v), 0, 0, vt[v].dat);
        end

`ifdef RECEPTOR_PARIDADE_EN
        do_reset();
        pulse_iniciar();
        send_byte(8'h31, 1'b1, 1'b1);
        chk("par_erro", erro, 1);
        chk("par_nwr", wq.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/receptor_movimentos.md
# receptor_movimentos

Receives the solution move list from the host PC over the serial line and writes it, one 3-bit code per entry, into the movement RAM that the servo manager later reads. It holds an internal 8N1 UART receiver, decodes ASCII move characters into move codes, generates sequential RAM write addresses, and reports completion or error to the main control unit. It is the writer side of the movement RAM: the datapath's move counter reads the entries back in order.

## Interface
- CLKS_POR_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud).
- MAX_MOVIMENTOS, default 480: movement RAM depth and maximum list length.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- iniciar  in  1  one-cycle start pulse from the control unit.
- rx_serial  in  1  serial line from the host, idle high.
- w_addr_movimento  out  9  RAM write address, equal to the current move count.
- we_movimento  out  1  RAM write enable, one-cycle pulse per stored move.
- w_data_movimento  out  3  decoded move code.
- num_movimentos  out  9  number of moves stored so far.
- pronto  out  1  high while in FINAL; reception ended with terminator or full RAM.
- erro  out  1  high while in ERRO; invalid byte, framing or parity error.
- db_estado  out  4  current main FSM state code, for debug.

## Operation
- rx_serial passes through a 2-flop synchronizer before use.
- UART sub-FSM: OCIOSO -> START on a falling edge. At CLKS_POR_BIT/2 the line is resampled; if high, it is a false start and the FSM returns to OCIOSO. Otherwise 8 data bits are sampled LSB first, each CLKS_POR_BIT apart, then STOP is sampled. The result is a one-cycle byte_valido, plus a framing error when STOP reads 0.
- Main FSM states:
  - INICIAL (0): idle after reset.
  - ESPERA (1): on iniciar, count is cleared.
  - DECODIFICA (2): entered on byte_valido.
  - ESCREVE (3)
  - INCREMENTA (4)
  - FINAL (5)
  - ERRO (6)
- Decoding:
  - 0x30..0x35 ('0'..'5') -> codes 0..5, then go to ESCREVE.
  - 0x23 ('#') -> FINAL with no write.
  - Any other byte, or a framing error -> ERRO.
- ESCREVE: we_movimento=1, w_addr_movimento=count, w_data_movimento=code, for exactly one cycle.
- INCREMENTA: count+1. If count = MAX_MOVIMENTOS the FSM goes to FINAL, otherwise back to ESPERA.
- FINAL and ERRO hold their flag until iniciar, which clears count and re-enters ESPERA.
- iniciar is ignored in ESPERA, DECODIFICA, ESCREVE and INCREMENTA.
- Codes 6 and 7 are never written.

## Timing
- Reset values:
  - all outputs 0: w_addr_movimento, we_movimento, w_data_movimento, num_movimentos, pronto, erro;
  - db_estado = 0;
  - UART in OCIOSO.
- Latency from the centre of the stop bit to byte_valido is 1 cycle. The we_movimento pulse follows byte_valido by 2 cycles.
- Address width: count is 9 bits and never exceeds MAX_MOVIMENTOS; there is no wrap-around.
- A byte arriving while the main FSM is in DECODIFICA/ESCREVE/INCREMENTA is not lost: the UART keeps receiving, because those states last 3 cycles, far below one bit time.
- Bytes arriving in INICIAL, FINAL or ERRO are received and discarded.
- Reset mid-frame or mid-list aborts immediately. Already written RAM entries are untouched, but num_movimentos returns to 0.

## Configuration
- RECEPTOR_PARIDADE_EN:
  - Defined: frame is 8E1. A parity bit is sampled after bit 7 and before STOP. Odd total parity over data+parity is treated like a framing error and leads to ERRO.
  - Undefined: frame is 8N1, there is no parity logic, and the bit after bit 7 is STOP.

## Test plan
- Full list (CLKS_POR_BIT=16): reset, iniciar, send "3","0","5","#" -> writes (addr 0,data 3), (1,0), (2,5); pronto=1; num_movimentos=3; erro=0.
- Invalid byte: iniciar, send "2","X" -> one write (0,2), then erro=1, pronto=0, num_movimentos=1. A further "1" produces no write.
- Framing error: frame with STOP=0 carrying '1' -> erro=1, no we_movimento pulse.
- False start: a 4-cycle low glitch on rx_serial in ESPERA -> no byte_valido, FSM stays in ESPERA (db_estado=1).
- Full RAM (MAX_MOVIMENTOS=4): send "1" five times -> 4 writes at addresses 0..3, pronto=1 after the 4th, the 5th byte is ignored.
- Reset mid-operation: assert reset during bit 4 of the 2nd byte -> all outputs 0 at once; after release, iniciar and "4","#" write (0,4).
- With RECEPTOR_PARIDADE_EN: bad parity on '1' -> erro=1, no write.
